// File: rtl/ripple_count_monitor_if.sv
// Bus between the ripple counter consumer and its environment: counter input,
// snapshot handshake and status flags.
interface ripple_count_monitor_if #(
  parameter int unsigned ACC_W = 16
) ();
  logic [3:0]       cnt_in;
  logic             sample_req;
  logic             out_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_count;
  logic             acc_ovf;
  logic             req_drop;
  logic             locked;
  logic             stall;

  modport master (
    output cnt_in, sample_req, out_ready,
    input  out_valid, out_count, acc_ovf, req_drop, locked, stall
  );

  modport slave (
    input  cnt_in, sample_req, out_ready,
    output out_valid, out_count, acc_ovf, req_drop, locked, stall
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronises and filters a 4-bit ripple counter, extends it by modulo-16 delta
// accumulation and returns snapshots over valid/ready. Optional stall timer: RCM_TIMEOUT_EN.
module ripple_count_monitor #(
  parameter int unsigned ACC_W          = 16,
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst,
  ripple_count_monitor_if.slave io_bus
);

  typedef enum logic [0:0] {StFill, StTrack} state_e;

  localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

  logic [3:0]       r_s1, r_s2, r_cand, r_stab, r_base;
  logic [1:0]       r_fill;
  logic [ACC_W-1:0] r_acc, r_out_count;
  logic             r_out_valid, r_acc_ovf, r_req_drop, r_locked;
  state_e           r_state;

  logic             w_accept;
  logic [3:0]       w_delta;
  logic [ACC_W:0]   w_sum;
  logic             w_load, w_drop, w_stall;

  // The filter only runs once s2 holds a real sample, so the reset value of the
  // sync flops is never mistaken for a stable count.
  always_comb begin
    w_accept = 1'b0;
    if (r_fill[1]) begin
      if (r_s2 != r_cand) begin
        w_accept = (StableCnt == 4'd1);
      end else if (r_stab < StableCnt) begin
        w_accept = ((r_stab + 4'd1) == StableCnt);
      end
    end
  end

  // On an accept cycle the new candidate equals s2.
  assign w_delta = r_s2 - r_base;
  assign w_sum   = {1'b0, r_acc} + {{(ACC_W - 3){1'b0}}, w_delta};
  assign w_load  = io_bus.sample_req && (r_state == StTrack) &&
                   (!r_out_valid || io_bus.out_ready);
  assign w_drop  = io_bus.sample_req && !w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1        <= 4'd0;
      r_s2        <= 4'd0;
      r_fill      <= 2'b00;
      r_cand      <= 4'd0;
      r_stab      <= 4'd0;
      r_base      <= 4'd0;
      r_acc       <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      r_acc_ovf   <= 1'b0;
      r_req_drop  <= 1'b0;
      r_locked    <= 1'b0;
      r_state     <= StFill;
    end else begin
      r_s1   <= io_bus.cnt_in;
      r_s2   <= r_s1;
      r_fill <= {r_fill[0], 1'b1};

      if (r_fill[1]) begin
        if (r_s2 != r_cand) begin
          r_cand <= r_s2;
          r_stab <= 4'd1;
        end else if (r_stab < StableCnt) begin
          r_stab <= r_stab + 4'd1;
        end
      end

      case (r_state)
        StFill: begin
          if (w_accept) begin
            r_base   <= r_s2;
            r_locked <= 1'b1;
            r_state  <= StTrack;
          end
        end
        StTrack: begin
          if (w_accept) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_base <= r_s2;
            if (w_sum[ACC_W]) r_acc_ovf <= 1'b1;
          end
        end
        default: r_state <= StFill;
      endcase

      // Snapshot takes the pre-update accumulator when it coincides with an accept.
      if (w_load) begin
        r_out_count <= r_acc;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop) r_req_drop <= 1'b1;
    end
  end

`ifdef RCM_TIMEOUT_EN
  localparam int unsigned      TmrW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmrW-1:0]  TmrMax = TmrW'(TIMEOUT_CYCLES);

  logic [TmrW-1:0] r_tmr;
  logic            r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr   <= '0;
      r_stall <= 1'b0;
    end else if (r_state != StTrack || w_accept) begin
      r_tmr   <= '0;
      r_stall <= 1'b0;
    end else begin
      if (r_tmr != TmrMax) r_tmr <= r_tmr + TmrW'(1);
      if (r_tmr == TmrMax - TmrW'(1)) r_stall <= 1'b1;
    end
  end

  assign w_stall = r_stall;
`else
  assign w_stall = 1'b0;
`endif

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_count = r_out_count;
  assign io_bus.acc_ovf   = r_acc_ovf;
  assign io_bus.req_drop  = r_req_drop;
  assign io_bus.locked    = r_locked;
  assign io_bus.stall     = w_stall;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: table of counter steps with expected
// snapshots, plus hand sequences for glitch, handshake, overflow, reset and stall.
module tb_ripple_count_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ripple_count_monitor_if #(.ACC_W(16)) bus ();
  ripple_count_monitor_if #(.ACC_W(5))  bus5 ();

  ripple_count_monitor #(
    .ACC_W(16), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );

  ripple_count_monitor #(
    .ACC_W(5), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(1024)
  ) dut5 (
    .clk(clk), .rst(rst), .io_bus(bus5)
  );

  typedef struct {
    logic [3:0]  cnt;
    int          hold;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[14];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef RCM_TIMEOUT_EN
  localparam logic ExpStall = 1'b1;
`else
  localparam logic ExpStall = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle request with out_ready high; the snapshot is consumed on the next edge.
  task automatic request(input string name, input logic [15:0] exp);
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    check({name, " valid"}, 32'(bus.out_valid), 32'd1);
    check({name, " count"}, 32'(bus.out_count), 32'(exp));
    tick(1);
  endtask

  initial begin
    vecs = '{
      '{4'd5,  6, 16'd0},  '{4'd6,  6, 16'd1},  '{4'd7,  6, 16'd2},  '{4'd8,  6, 16'd3},
      '{4'd9,  6, 16'd4},  '{4'd10, 6, 16'd5},  '{4'd11, 6, 16'd6},  '{4'd12, 6, 16'd7},
      '{4'd13, 6, 16'd8},  '{4'd14, 6, 16'd9},  '{4'd15, 6, 16'd10}, '{4'd0,  6, 16'd11},
      '{4'd1,  6, 16'd12}, '{4'd2,  6, 16'd13}
    };

    rst             = 1'b1;
    bus.cnt_in      = 4'd5;
    bus.sample_req  = 1'b0;
    bus.out_ready   = 1'b1;
    bus5.cnt_in     = 4'd0;
    bus5.sample_req = 1'b0;
    bus5.out_ready  = 1'b1;
    tick(2);

    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_count", 32'(bus.out_count), 32'd0);
    check("rst locked",    32'(bus.locked),    32'd0);
    check("rst acc_ovf",   32'(bus.acc_ovf),   32'd0);
    check("rst req_drop",  32'(bus.req_drop),  32'd0);
    check("rst stall",     32'(bus.stall),     32'd0);

    rst = 1'b0;
    tick(3);
    check("lock early", 32'(bus.locked), 32'd0);
    tick(1);
    check("lock at 4",  32'(bus.locked), 32'd1);

    for (int i = 0; i < 14; i++) begin
      bus.cnt_in = vecs[i].cnt;
      tick(vecs[i].hold);
      request($sformatf("vec%0d", i), vecs[i].exp_count);
    end
    check("consumed valid", 32'(bus.out_valid), 32'd0);

    // One-cycle glitch must not move the accumulator.
    bus.cnt_in = 4'd9;
    tick(1);
    bus.cnt_in = 4'd2;
    tick(6);
    request("glitch", 16'd13);

    // Request landing on the accept edge snapshots the old value.
    bus.cnt_in = 4'd3;
    tick(3);
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    check("pre-update count", 32'(bus.out_count), 32'd13);
    tick(5);
    request("post-update", 16'd14);

    // Backpressure: second request dropped, then ready+req reloads in one cycle.
    bus.out_ready  = 1'b0;
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    check("hs valid",     32'(bus.out_valid), 32'd1);
    check("hs count",     32'(bus.out_count), 32'd14);
    check("hs no drop",   32'(bus.req_drop),  32'd0);
    bus.cnt_in = 4'd4;
    tick(6);
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    check("drop flag",    32'(bus.req_drop),  32'd1);
    check("drop count",   32'(bus.out_count), 32'd14);
    check("drop valid",   32'(bus.out_valid), 32'd1);
    bus.out_ready  = 1'b1;
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    check("reload valid", 32'(bus.out_valid), 32'd1);
    check("reload count", 32'(bus.out_count), 32'd15);
    tick(1);
    check("reload done",  32'(bus.out_valid), 32'd0);

    // 5-bit accumulator wraps after 32 increments.
    for (int i = 1; i <= 40; i++) begin
      bus5.cnt_in = 4'(i);
      tick(5);
      if (i == 31) check("ovf before wrap", 32'(bus5.acc_ovf), 32'd0);
      if (i == 32) check("ovf at wrap",     32'(bus5.acc_ovf), 32'd1);
    end
    bus5.sample_req = 1'b1;
    tick(1);
    bus5.sample_req = 1'b0;
    check("wrap valid", 32'(bus5.out_valid), 32'd1);
    check("wrap count", 32'(bus5.out_count), 32'd8);

    // Reset with a snapshot pending clears everything.
    bus.out_ready  = 1'b0;
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    check("pending valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid-rst valid",    32'(bus.out_valid), 32'd0);
    check("mid-rst count",    32'(bus.out_count), 32'd0);
    check("mid-rst locked",   32'(bus.locked),    32'd0);
    check("mid-rst drop",     32'(bus.req_drop),  32'd0);
    check("mid-rst stall",    32'(bus.stall),     32'd0);
    check("mid-rst ovf5",     32'(bus5.acc_ovf),  32'd0);
    bus.cnt_in    = 4'd5;
    bus.out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("relock early", 32'(bus.locked), 32'd0);
    tick(1);
    check("relock",       32'(bus.locked), 32'd1);

    // Frozen counter: stall after 16 cycles in TRACK when the timer is built in.
    tick(10);
    check("stall early", 32'(bus.stall), 32'd0);
    tick(10);
    check("stall set",   32'(bus.stall), 32'(ExpStall));
    bus.cnt_in = 4'd6;
    tick(6);
    check("stall clear", 32'(bus.stall), 32'd0);
    request("after reset", 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
